pcm_frame_sched: RTL and testbench



---
 rtl/pcm_frame_sched_pkg.sv | 23 ++
 rtl/pcm_tx_tracker.sv | 83 ++++++++
 rtl/pcm_frame_sched.sv | 182 ++++++++++++++++++
 tb/tb_pcm_frame_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_frame_sched_pkg.sv
// Shared defaults, write-FSM state encoding and half-buffer size helper for pcm_frame_sched.
package pcm_frame_sched_pkg;

    localparam int NCHAN_DEF   = 16;
    localparam int NFRAMES_DEF = 16;
    localparam int HDR_DEF     = 14;
    localparam int ADDR_W_DEF  = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_LO   = 3'd1,
        ST_WR_HI   = 3'd2,
        ST_NEXT    = 3'd3,
        ST_SEQ_HI  = 3'd4,
        ST_SEQ_LO  = 3'd5,
        ST_HANDOFF = 3'd6
    } wr_state_e;

    function automatic int half_bytes(input int addr_w);
        return 1 << (addr_w - 1);
    endfunction

endpackage

// File: rtl/pcm_tx_tracker.sv
// Pending-frame / outstanding-start bookkeeping for the Ethernet transmitter, plus
// eth_start generation and the saturating overrun counter.
module pcm_tx_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       handoff_i,
    input  logic       handoff_half_i,
    input  logic       eth_busy_i,
    output logic       accept_o,
    output logic       eth_start_o,
    output logic       eth_half_o,
    output logic [7:0] overrun_cnt_o
);

    logic       pend_q, pend_d;
    logic       pend_half_q, pend_half_d;
    logic       outst_q, outst_d;
    logic [1:0] wait_q, wait_d;
    logic       start_q, start_d;
    logic       half_q, half_d;
    logic [7:0] ovr_q, ovr_d;
    logic       launch;

    assign launch   = pend_q && !eth_busy_i && !outst_q;
    // A launch in the same cycle frees the pending slot before the handoff looks at it.
    assign accept_o = !pend_q || launch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_half_q <= 1'b0;
            outst_q     <= 1'b0;
            wait_q      <= 2'd0;
            start_q     <= 1'b0;
            half_q      <= 1'b0;
            ovr_q       <= 8'd0;
        end else begin
            pend_q      <= pend_d;
            pend_half_q <= pend_half_d;
            outst_q     <= outst_d;
            wait_q      <= wait_d;
            start_q     <= start_d;
            half_q      <= half_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        pend_d      = pend_q;
        pend_half_d = pend_half_q;
        outst_d     = outst_q;
        wait_d      = wait_q;
        start_d     = 1'b0;
        half_d      = half_q;
        ovr_d       = ovr_q;
        if (launch) begin
            start_d = 1'b1;
            half_d  = pend_half_q;
            pend_d  = 1'b0;
            outst_d = 1'b1;
            wait_d  = 2'd0;
        end else if (outst_q) begin
            if (eth_busy_i || wait_q == 2'd3) begin
                outst_d = 1'b0;
            end else begin
                wait_d = wait_q + 2'd1;
            end
        end
        if (handoff_i) begin
            if (accept_o) begin
                pend_d      = 1'b1;
                pend_half_d = handoff_half_i;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end
    end

    assign eth_start_o   = start_q;
    assign eth_half_o    = half_q;
    assign overrun_cnt_o = ovr_q;

endmodule

// File: rtl/pcm_frame_sched.sv
// Ping-pong PCM frame writer: walks the channel mux per strobe and fills one BRAM half.
// Define FRAME_SEQ_EN to prefix each half with a big-endian 16-bit frame sequence number.
module pcm_frame_sched
    import pcm_frame_sched_pkg::*;
#(
    parameter int NCHAN   = NCHAN_DEF,
    parameter int NFRAMES = NFRAMES_DEF,
    parameter int HDR     = HDR_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pcm_stb,
    output logic [$clog2(NCHAN)-1:0] chan_sel,
    input  logic [15:0]              pcm_data,
    output logic                     bram_wr_en,
    output logic [ADDR_W-1:0]        bram_wr_addr,
    output logic [7:0]               bram_wr_data,
    output logic                     eth_start,
    output logic                     eth_half,
    input  logic                     eth_busy,
    output logic [7:0]               overrun_cnt,
    output logic                     late_err
);

    localparam int CW   = $clog2(NCHAN);
    localparam int SW   = (NFRAMES > 1) ? $clog2(NFRAMES) : 1;
    localparam int HALF = half_bytes(ADDR_W);
`ifdef FRAME_SEQ_EN
    localparam int PAY  = HDR + 2;
`else
    localparam int PAY  = HDR;
`endif

    wr_state_e         state_q, state_d;
    logic [CW-1:0]     chan_q, chan_d;
    logic [SW-1:0]     set_q, set_d;
    logic              half_q, half_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              late_q, late_d;
    logic              handoff, accept;
    logic [ADDR_W-1:0] sample_addr;
`ifdef FRAME_SEQ_EN
    logic [15:0]       seq_q, seq_d;
    logic [ADDR_W-1:0] seq_addr;

    assign seq_addr = ADDR_W'(HALF * int'(half_q) + HDR);
`endif

    assign sample_addr = ADDR_W'(HALF * int'(half_q) + PAY
                                 + int'(set_q) * 2 * NCHAN + int'(chan_q) * 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
            set_q   <= '0;
            half_q  <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'd0;
            late_q  <= 1'b0;
`ifdef FRAME_SEQ_EN
            seq_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            set_q   <= set_d;
            half_q  <= half_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            late_q  <= late_d;
`ifdef FRAME_SEQ_EN
            seq_q   <= seq_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        set_d   = set_q;
        half_d  = half_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        late_d  = late_q;
        handoff = 1'b0;
`ifdef FRAME_SEQ_EN
        seq_d   = seq_q;
`endif
        if (pcm_stb && state_q != ST_IDLE) late_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (pcm_stb) begin
                    chan_d  = '0;
                    state_d = ST_WR_LO;
                end
            end
            // chan_sel holds across LO/HI so both bytes come from the same mux sample.
            ST_WR_LO: begin
                wr_en_d = 1'b1;
                addr_d  = sample_addr;
                data_d  = pcm_data[7:0];
                state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                wr_en_d = 1'b1;
                addr_d  = sample_addr + ADDR_W'(1);
                data_d  = pcm_data[15:8];
                if (chan_q == CW'(NCHAN - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    chan_d  = chan_q + 1'b1;
                    state_d = ST_WR_LO;
                end
            end
            ST_NEXT: begin
                if (set_q == SW'(NFRAMES - 1)) begin
                    set_d = '0;
`ifdef FRAME_SEQ_EN
                    state_d = ST_SEQ_HI;
`else
                    state_d = ST_HANDOFF;
`endif
                end else begin
                    set_d   = set_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
`ifdef FRAME_SEQ_EN
            ST_SEQ_HI: begin
                wr_en_d = 1'b1;
                addr_d  = seq_addr;
                data_d  = seq_q[15:8];
                state_d = ST_SEQ_LO;
            end
            ST_SEQ_LO: begin
                wr_en_d = 1'b1;
                addr_d  = seq_addr + ADDR_W'(1);
                data_d  = seq_q[7:0];
                state_d = ST_HANDOFF;
            end
`endif
            // On overrun the same half is refilled; sequence number is reused.
            ST_HANDOFF: begin
                handoff = 1'b1;
                if (accept) begin
                    half_d = ~half_q;
`ifdef FRAME_SEQ_EN
                    seq_d  = seq_q + 16'd1;
`endif
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    pcm_tx_tracker u_tx (
        .clk           (clk),
        .rst           (rst),
        .handoff_i     (handoff),
        .handoff_half_i(half_q),
        .eth_busy_i    (eth_busy),
        .accept_o      (accept),
        .eth_start_o   (eth_start),
        .eth_half_o    (eth_half),
        .overrun_cnt_o (overrun_cnt)
    );

    assign chan_sel     = chan_q;
    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = addr_q;
    assign bram_wr_data = data_q;
    assign late_err     = late_q;

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Bench for pcm_frame_sched: frame-level model of BRAM writes, transmitter handoffs and overruns.
// Honours FRAME_SEQ_EN the same way as the design.
module tb_pcm_frame_sched;

    localparam int NCHAN   = 16;
    localparam int NFRAMES = 16;
    localparam int HDR     = 14;
    localparam int HALF    = 1024;
`ifdef FRAME_SEQ_EN
    localparam int PAY = HDR + 2;
    localparam bit SEQ = 1'b1;
`else
    localparam int PAY = HDR;
    localparam bit SEQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pcm_stb;
    logic [3:0]  chan_sel;
    logic [15:0] pcm_data;
    logic        bram_wr_en;
    logic [10:0] bram_wr_addr;
    logic [7:0]  bram_wr_data;
    logic        eth_start;
    logic        eth_half;
    logic        eth_busy;
    logic [7:0]  overrun_cnt;
    logic        late_err;

    logic [15:0] samp [NCHAN];
    assign pcm_data = samp[chan_sel];

    pcm_frame_sched dut (
        .clk(clk), .rst(rst), .pcm_stb(pcm_stb), .chan_sel(chan_sel), .pcm_data(pcm_data),
        .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
        .eth_start(eth_start), .eth_half(eth_half), .eth_busy(eth_busy),
        .overrun_cnt(overrun_cnt), .late_err(late_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] exp_q[$];
    logic        exp_tx_q[$];
    logic        last_half = 1'b0;

    // Frame-level model state
    int          wr_half_m, set_m, ovr_m, seq_m, pend_half_m, rel_at, set_no;
    bit          pend_m, busy_m, late_m;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (eth_start === 1'b1) eth_busy = 1'b1;
    endtask

    task automatic model_reset();
        wr_half_m = 0; set_m = 0; ovr_m = 0; seq_m = 0; pend_half_m = 0;
        pend_m = 1'b0; busy_m = 1'b0; late_m = 1'b0;
        exp_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic try_launch();
        if (!busy_m && pend_m) begin
            exp_tx_q.push_back(pend_half_m[0]);
            pend_m = 1'b0;
            busy_m = 1'b1;
            rel_at = set_no + int'($urandom_range(1, 48));
        end
    endtask

    task automatic model_set();
        int a;
        for (int c = 0; c < NCHAN; c++) begin
            a = wr_half_m * HALF + PAY + set_m * 2 * NCHAN + 2 * c;
            exp_q.push_back({11'(a), samp[c][7:0]});
            exp_q.push_back({11'(a + 1), samp[c][15:8]});
        end
        set_m++;
        if (set_m == NFRAMES) begin
            set_m = 0;
            if (SEQ) begin
                a = wr_half_m * HALF + HDR;
                exp_q.push_back({11'(a), 8'(seq_m >> 8)});
                exp_q.push_back({11'(a + 1), 8'(seq_m)});
            end
            if (pend_m) begin
                if (ovr_m < 255) ovr_m++;
            end else begin
                pend_m = 1'b1;
                pend_half_m = wr_half_m;
                wr_half_m = 1 - wr_half_m;
                seq_m = (seq_m + 1) & 16'hFFFF;
            end
        end
    endtask

    // mode: 0 random, 1 directed first set + timing, 2 late strobe, 3 reset mid-write
    task automatic run_set(input int mode, input bit post_reset);
        check("overrun_cnt", overrun_cnt, ovr_m);
        check("late_err", late_err, late_m);
        if (busy_m && set_no >= rel_at) begin
            eth_busy = 1'b0;
            busy_m = 1'b0;
        end
        try_launch();
        for (int c = 0; c < NCHAN; c++)
            samp[c] = (mode == 1) ? 16'(16'h0100 + c) : 16'($urandom);
        model_set();
        try_launch();
        if (mode == 1) begin
            check("model_b0", exp_q[0], {11'(PAY), 8'h00});
            check("model_b1", exp_q[1], {11'(PAY + 1), 8'h01});
            check("model_b2", exp_q[2], {11'(PAY + 2), 8'h01});
            check("model_b3", exp_q[3], {11'(PAY + 3), 8'h01});
        end
        if (set_no == 15) begin
            check("model_launch_cnt", exp_tx_q.size(), 1);
            if (SEQ) begin
                check("model_seq0_hi", exp_q[32], {11'(HDR), 8'h00});
                check("model_seq0_lo", exp_q[33], {11'(HDR + 1), 8'h00});
            end
        end
        if (set_no == 16) check("model_half1_base", exp_q[0][18:8], HALF + PAY);
        if (set_no == 31 && SEQ) begin
            check("model_seq1_hi", exp_q[32], {11'(HALF + HDR), 8'h00});
            check("model_seq1_lo", exp_q[33], {11'(HALF + HDR + 1), 8'h01});
        end
        if (post_reset) check("model_after_reset_base", exp_q[0][18:8], PAY);
        pcm_stb = 1'b1;
        tick();
        pcm_stb = 1'b0;
        if (mode == 1) begin
            repeat (32) tick();
            check("wr_en_last_byte", bram_wr_en, 1);
            tick();
            check("wr_en_after_set", bram_wr_en, 0);
        end else if (mode == 2) begin
            repeat (9) tick();
            pcm_stb = 1'b1;
            tick();
            pcm_stb = 1'b0;
            late_m = 1'b1;
        end else if (mode == 3) begin
            repeat (20) tick();
            rst = 1'b1;
            #1;
            check("reset_mid_write",
                  {bram_wr_en, bram_wr_addr, bram_wr_data, chan_sel, eth_start, eth_half,
                   overrun_cnt, late_err}, 0);
            model_reset();
            eth_busy = 1'b0;
            repeat (3) tick();
            rst = 1'b0;
        end
        repeat ($urandom_range(40, 50)) tick();
        set_no++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bram_write: got %0h with no write expected",
                             {bram_wr_addr, bram_wr_data});
                end else begin
                    check("bram_write", {bram_wr_addr, bram_wr_data}, exp_q.pop_front());
                end
            end
            if (eth_start) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL eth_start: got half %0d with no launch expected", eth_half);
                end else begin
                    check("eth_start_half", eth_half, exp_tx_q.pop_front());
                end
                last_half = eth_half;
            end else if (eth_busy) begin
                check("eth_half_hold", eth_half, last_half);
            end
        end
    end

    initial begin
        rst = 1'b1;
        pcm_stb = 1'b0;
        eth_busy = 1'b0;
        set_no = 0;
        rel_at = 0;
        for (int c = 0; c < NCHAN; c++) samp[c] = 16'd0;
        model_reset();
        repeat (3) tick();
        check("reset_outputs",
              {bram_wr_en, bram_wr_addr, bram_wr_data, chan_sel, eth_start, eth_half,
               overrun_cnt, late_err}, 0);
        rst = 1'b0;
        tick();
        run_set(1, 1'b0);
        run_set(2, 1'b0);
        for (int i = 2; i < 60; i++) run_set(0, 1'b0);
        run_set(3, 1'b0);
        run_set(0, 1'b1);
        for (int i = 62; i < 120; i++) run_set(0, 1'b0);
        repeat (10) tick();
        check("final_overrun_cnt", overrun_cnt, ovr_m);
        check("final_writes_left", exp_q.size(), 0);
        check("final_launches_left", exp_tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
